// File: rtl/key_entry_buffer_if.sv
// Keypad-to-display/core bundle for the numeric entry buffer.
// The slave side is the entry buffer; the master side is the scanner/display/core.
interface key_entry_buffer_if #(
    parameter int unsigned DIGITS = 8
);
    logic [15:0]         key_pulse;
    logic [4*DIGITS-1:0] seg_data;
    logic [DIGITS-1:0]   seg_data_en;
    logic [DIGITS-1:0]   seg_dot_en;
    logic [3:0]          digit_cnt;
    logic [4*DIGITS-1:0] entry_value;
    logic                entry_valid;
    logic [1:0]          op_code;
    logic                op_valid;
    logic                overflow;

    modport master (
        output key_pulse,
        input  seg_data, seg_data_en, seg_dot_en, digit_cnt,
        input  entry_value, entry_valid, op_code, op_valid, overflow
    );

    modport slave (
        input  key_pulse,
        output seg_data, seg_data_en, seg_dot_en, digit_cnt,
        output entry_value, entry_valid, op_code, op_valid, overflow
    );
endinterface

// File: rtl/key_entry_buffer.sv
// N-digit hex entry editor: shifts digits in from the right, supports backspace,
// clear, enter and operators, and blinks digit 0's dot while the buffer is full.
module key_entry_buffer #(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned BLINK_CYCLES = 25000000
) (
    input logic             clk,
    input logic             rst_n,
    key_entry_buffer_if.slave bus
);
    localparam int unsigned BW       = $clog2(BLINK_CYCLES);
    localparam logic [BW-1:0] BlinkMax = BW'(BLINK_CYCLES - 1);
    localparam logic [3:0]  CntFull  = 4'(DIGITS);

    logic [4*DIGITS-1:0] data_q, data_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DIGITS-1:0]   en_q, en_d;
    logic                ovf_q, ovf_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic                evld_q, evld_d;
    logic [1:0]          opc_q, opc_d;
    logic                opv_q, opv_d;
    logic [BW-1:0]       blink_q, blink_d;
    logic                phase_q, phase_d;

    logic                key_valid;
    logic [3:0]          key_idx;
    logic [3:0]          digit;
    logic                op_key;
    logic [1:0]          op_sel;

    // Decode the key, edit the buffer and derive display/blink next state.
    always_comb begin
        data_d  = data_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        value_d = value_q;
        evld_d  = 1'b0;
        opc_d   = opc_q;
        opv_d   = 1'b0;
        en_d    = '0;
        blink_d = '0;
        phase_d = 1'b0;
        key_idx = 4'd0;
        digit   = 4'd0;
        op_key  = 1'b0;
        op_sel  = 2'd0;

        key_valid = $onehot(bus.key_pulse);
        for (int i = 0; i < 16; i++) begin
            if (bus.key_pulse[i]) key_idx = 4'(i);
        end

        if (key_valid) begin
            case (key_idx)
                4'd9: begin
                    if (cnt_q != 4'd0) begin
                        data_d = {4'h0, data_q[4*DIGITS-1:4]};
                        cnt_d  = cnt_q - 4'd1;
                    end
                end
                4'd10: begin
                    data_d = '0;
                    cnt_d  = 4'd0;
                    ovf_d  = 1'b0;
                end
                4'd11: begin op_key = 1'b1; op_sel = 2'd3; end
                4'd12: begin op_key = 1'b1; op_sel = 2'd0; end
                4'd13: begin op_key = 1'b1; op_sel = 2'd1; end
                4'd14: begin op_key = 1'b1; op_sel = 2'd2; end
                default: begin
                    // Bits 0..8 are digits 1..9, bit 15 is digit 0.
                    digit = (key_idx == 4'd15) ? 4'd0 : key_idx + 4'd1;
                    if (cnt_q == CntFull) begin
                        ovf_d = 1'b1;
                    end else if (!(digit == 4'd0 && cnt_q == 4'd0)) begin
                        data_d = {data_q[4*DIGITS-5:0], digit};
                        cnt_d  = cnt_q + 4'd1;
                    end
                end
            endcase
        end

        if (op_key) begin
            value_d = data_q;
            evld_d  = 1'b1;
            opv_d   = 1'b1;
            opc_d   = op_sel;
            data_d  = '0;
            cnt_d   = 4'd0;
            ovf_d   = 1'b0;
        end

        // Digit 0 is always lit so an empty buffer shows "0".
        for (int unsigned i = 0; i < DIGITS; i++) begin
            en_d[i] = (i == 0) || (i < 32'(cnt_d));
        end

        // Blink only while the buffer stays full; leaving it zeroes counter and phase.
        if (cnt_d == CntFull && cnt_q == CntFull) begin
            if (blink_q == BlinkMax) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + BW'(1);
                phase_d = phase_q;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            cnt_q   <= 4'd0;
            en_q    <= DIGITS'(1);
            ovf_q   <= 1'b0;
            value_q <= '0;
            evld_q  <= 1'b0;
            opc_q   <= 2'd0;
            opv_q   <= 1'b0;
            blink_q <= '0;
            phase_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            ovf_q   <= ovf_d;
            value_q <= value_d;
            evld_q  <= evld_d;
            opc_q   <= opc_d;
            opv_q   <= opv_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
        end
    end

    assign bus.seg_data    = data_q;
    assign bus.seg_data_en = en_q;
    assign bus.seg_dot_en  = {{(DIGITS-1){1'b0}}, phase_q};
    assign bus.digit_cnt   = cnt_q;
    assign bus.entry_value = value_q;
    assign bus.entry_valid = evld_q;
    assign bus.op_code     = opc_q;
    assign bus.op_valid    = opv_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_key_entry_buffer.sv
// Self-checking bench for key_entry_buffer (DIGITS=8, BLINK_CYCLES=4).
module tb_key_entry_buffer;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned BLINK  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_entry_buffer_if #(.DIGITS(DIGITS)) bus ();

    key_entry_buffer #(.DIGITS(DIGITS), .BLINK_CYCLES(BLINK)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] value;
        logic [1:0]  code;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    // Strobe scoreboard: every strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus.entry_valid || bus.op_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe got ev=%0b ov=%0b val=%h required none",
                         bus.entry_valid, bus.op_valid, bus.entry_value);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.entry_valid, bus.op_valid, bus.op_code, bus.entry_value} !==
                    {1'b1, 1'b1, mon_e.code, mon_e.value}) begin
                    failures++;
                    $display("FAIL strobe got ev=%0b ov=%0b op=%0d val=%h required op=%0d val=%h",
                             bus.entry_valid, bus.op_valid, bus.op_code, bus.entry_value,
                             mon_e.code, mon_e.value);
                end
            end
        end
    end

    function automatic logic [15:0] dkey(input int d);
        logic [15:0] k;
        k = (d == 0) ? 16'h8000 : (16'h0001 << (d - 1));
        return k;
    endfunction

    task automatic press(input logic [15:0] k);
        @(negedge clk) bus.key_pulse = k;
        @(negedge clk) bus.key_pulse = '0;
    endtask

    task automatic do_reset();
        bus.key_pulse = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.key_pulse = '0;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus.seg_data, bus.digit_cnt, bus.seg_data_en, bus.seg_dot_en} !==
            {32'h0, 4'd0, 8'h01, 8'h00}) begin
            failures++;
            $display("FAIL reset_display got %h/%0d/%h/%h required 0/0/01/00",
                     bus.seg_data, bus.digit_cnt, bus.seg_data_en, bus.seg_dot_en);
        end
        checks++;
        if ({bus.entry_value, bus.entry_valid, bus.op_code, bus.op_valid, bus.overflow} !==
            {32'h0, 1'b0, 2'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_core got val=%h ev=%0b op=%0d ov=%0b ovf=%0b required all 0",
                     bus.entry_value, bus.entry_valid, bus.op_code, bus.op_valid, bus.overflow);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_digits();
        do_reset();
        for (int d = 1; d <= 3; d++) begin
            press(dkey(d));
            repeat (8) @(negedge clk);
        end
        checks++;
        if ({bus.seg_data, bus.digit_cnt, bus.seg_data_en} !== {32'h123, 4'd3, 8'h07}) begin
            failures++;
            $display("FAIL digits_123 got %h/%0d/%h required 00000123/3/07",
                     bus.seg_data, bus.digit_cnt, bus.seg_data_en);
        end
    endtask

    task automatic test_leading_zero();
        do_reset();
        press(dkey(0));
        checks++;
        if ({bus.seg_data, bus.digit_cnt, bus.seg_data_en} !== {32'h0, 4'd0, 8'h01}) begin
            failures++;
            $display("FAIL leading_zero got %h/%0d/%h required 0/0/01",
                     bus.seg_data, bus.digit_cnt, bus.seg_data_en);
        end
        press(dkey(1));
        press(dkey(0));
        checks++;
        if ({bus.seg_data, bus.digit_cnt, bus.seg_data_en} !== {32'h10, 4'd2, 8'h03}) begin
            failures++;
            $display("FAIL digits_10 got %h/%0d/%h required 00000010/2/03",
                     bus.seg_data, bus.digit_cnt, bus.seg_data_en);
        end
    endtask

    task automatic test_no_action();
        do_reset();
        press(dkey(1));
        press(dkey(2));
        press(16'h0003);
        press(16'h0000);
        checks++;
        if ({bus.seg_data, bus.digit_cnt} !== {32'h12, 4'd2}) begin
            failures++;
            $display("FAIL multi_bit_key got %h/%0d required 00000012/2",
                     bus.seg_data, bus.digit_cnt);
        end
        press(16'h0400);
        press(16'h0400);
        press(16'h0200);
        checks++;
        if ({bus.seg_data, bus.digit_cnt, bus.seg_data_en, bus.overflow} !==
            {32'h0, 4'd0, 8'h01, 1'b0}) begin
            failures++;
            $display("FAIL clear_backspace_empty got %h/%0d/%h/%0b required 0/0/01/0",
                     bus.seg_data, bus.digit_cnt, bus.seg_data_en, bus.overflow);
        end
    endtask

    task automatic test_full_blink();
        logic prev;
        int   last_t;
        int   ntog;
        do_reset();
        for (int d = 1; d <= 8; d++) press(dkey(d));
        press(dkey(9));
        checks++;
        if ({bus.seg_data, bus.digit_cnt, bus.seg_data_en, bus.overflow} !==
            {32'h12345678, 4'd8, 8'hFF, 1'b1}) begin
            failures++;
            $display("FAIL full_overflow got %h/%0d/%h/%0b required 12345678/8/ff/1",
                     bus.seg_data, bus.digit_cnt, bus.seg_data_en, bus.overflow);
        end
        prev   = bus.seg_dot_en[0];
        last_t = -1;
        ntog   = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bus.seg_dot_en[0] !== prev) begin
                if (last_t >= 0) begin
                    checks++;
                    if (c - last_t != int'(BLINK)) begin
                        failures++;
                        $display("FAIL blink_period got %0d required %0d", c - last_t, BLINK);
                    end
                end
                last_t = c;
                ntog++;
                prev = bus.seg_dot_en[0];
            end
            if (bus.seg_dot_en[7:1] !== 7'h0) begin
                checks++;
                failures++;
                $display("FAIL blink_upper_dots got %h required 00", bus.seg_dot_en);
            end
        end
        checks++;
        if (ntog < 5) begin
            failures++;
            $display("FAIL blink_toggles got %0d required >=5", ntog);
        end
        press(16'h0200);
        checks++;
        if ({bus.seg_data, bus.digit_cnt, bus.seg_dot_en, bus.overflow} !==
            {32'h01234567, 4'd7, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL backspace_full got %h/%0d/%h/%0b required 01234567/7/00/1",
                     bus.seg_data, bus.digit_cnt, bus.seg_dot_en, bus.overflow);
        end
        press(16'h0400);
        checks++;
        if ({bus.seg_data, bus.digit_cnt, bus.overflow} !== {32'h0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL clear_overflow got %h/%0d/%0b required 0/0/0",
                     bus.seg_data, bus.digit_cnt, bus.overflow);
        end
    endtask

    task automatic test_operator();
        do_reset();
        for (int d = 1; d <= 3; d++) press(dkey(d));
        exp_q.push_back('{value: 32'h123, code: 2'd1});
        press(16'h2000);
        checks++;
        if ({bus.entry_valid, bus.seg_data, bus.digit_cnt, bus.seg_data_en} !==
            {1'b1, 32'h0, 4'd0, 8'h01}) begin
            failures++;
            $display("FAIL op_clear got ev=%0b %h/%0d/%h required 1 0/0/01",
                     bus.entry_valid, bus.seg_data, bus.digit_cnt, bus.seg_data_en);
        end
        @(negedge clk);
        checks++;
        if ({bus.entry_valid, bus.op_valid, bus.entry_value} !== {1'b0, 1'b0, 32'h123}) begin
            failures++;
            $display("FAIL op_one_cycle got ev=%0b ov=%0b val=%h required 0 0 00000123",
                     bus.entry_valid, bus.op_valid, bus.entry_value);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL op_scoreboard got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        exp_q.push_back('{value: 32'h0, code: 2'd3});
        exp_q.push_back('{value: 32'h5, code: 2'd0});
        exp_q.push_back('{value: 32'h0, code: 2'd2});
        @(negedge clk) bus.key_pulse = 16'h0800;
        @(negedge clk) bus.key_pulse = dkey(5);
        @(negedge clk) bus.key_pulse = 16'h1000;
        @(negedge clk) bus.key_pulse = 16'h4000;
        @(negedge clk) bus.key_pulse = dkey(7);
        @(negedge clk) bus.key_pulse = 16'h0200;
        @(negedge clk) bus.key_pulse = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_scoreboard got %0d pending required 0", exp_q.size());
        end
        checks++;
        if ({bus.seg_data, bus.digit_cnt} !== {32'h0, 4'd0}) begin
            failures++;
            $display("FAIL b2b_buffer got %h/%0d required 0/0", bus.seg_data, bus.digit_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        press(dkey(4));
        press(dkey(5));
        @(negedge clk) bus.key_pulse = 16'h0800;
        @(posedge clk);
        #2;
        checks++;
        if ({bus.entry_valid, bus.entry_value} !== {1'b1, 32'h45}) begin
            failures++;
            $display("FAIL strobe_in_flight got ev=%0b val=%h required 1 00000045",
                     bus.entry_valid, bus.entry_value);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.seg_data, bus.digit_cnt, bus.seg_data_en, bus.entry_value, bus.entry_valid,
             bus.op_valid, bus.op_code} !== {32'h0, 4'd0, 8'h01, 32'h0, 1'b0, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL async_reset got %h/%0d/%h val=%h ev=%0b ov=%0b op=%0d required 0/0/01 0",
                     bus.seg_data, bus.digit_cnt, bus.seg_data_en, bus.entry_value,
                     bus.entry_valid, bus.op_valid, bus.op_code);
        end
        @(negedge clk) bus.key_pulse = '0;
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.seg_data, bus.digit_cnt, bus.entry_value} !== {32'h0, 4'd0, 32'h0}) begin
            failures++;
            $display("FAIL after_reset got %h/%0d/%h required 0/0/0",
                     bus.seg_data, bus.digit_cnt, bus.entry_value);
        end
    endtask

    initial begin
        bus.key_pulse = '0;
        test_reset();
        test_digits();
        test_leading_zero();
        test_no_action();
        test_full_blink();
        test_operator();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/key_entry_buffer.md
Name: key_entry_buffer

Overview:
- Multi-digit numeric entry buffer for the calculator datapath.
- Consumes one-cycle one-hot key pulses from the 4x4 keypad scanner and maintains a right-aligned hex-digit entry register, shifted in as keys are typed.
- Drives packed digit, enable and dot buffers straight to the 74HC595 segment driver, and hands completed operands and operator codes to the calculator core.
- Replaces the single-digit latch with an N-digit editor that supports backspace, clear, enter, operators, leading-zero suppression and a full-buffer blink indication.

Parameters:
- DIGITS, 8, number of entry digits (2..8); digit 0 is the rightmost.
- BLINK_CYCLES, 25000000, clk cycles per half-period of the full-buffer dot blink (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_pulse  in  16  one-cycle one-hot key events from the keypad scanner
- seg_data  out  4*DIGITS  packed digits; [3:0] is digit 0 (rightmost)
- seg_data_en  out  DIGITS  per-digit display enable
- seg_dot_en  out  DIGITS  per-digit decimal-point enable
- digit_cnt  out  4  number of digits entered (0..DIGITS)
- entry_value  out  4*DIGITS  operand latched on enter or operator
- entry_valid  out  1  one-cycle strobe; entry_value is updated
- op_code  out  2  operator: 0=bit12, 1=bit13, 2=bit14, 3=enter
- op_valid  out  1  one-cycle strobe, coincident with entry_valid
- overflow  out  1  sticky flag: a digit key was pressed with the buffer full

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0 except seg_data_en = 1 (digit 0 enabled, showing "0"). The blink counter and blink phase are also cleared.
- Key decode:
  - bits 0..8 = digits 1..9; bit 15 = digit 0
  - bit 9 = backspace; bit 10 = clear; bit 11 = enter
  - bits 12..14 = operators
  - key_pulse == 0, or more than one bit set: no action.
- All state and outputs are registered. A key sampled at edge N is reflected in outputs after edge N; latency is 1 cycle.
- Digit key d with cnt < DIGITS:
  - seg_data <= {seg_data[4*DIGITS-5:0], d}; cnt <= cnt+1.
  - Exception: d=0 with cnt=0 is ignored (no leading zeros).
- Digit key with cnt == DIGITS: buffer unchanged; overflow <= 1.
- Backspace:
  - cnt > 0: seg_data <= {4'h0, seg_data[4*DIGITS-1:4]}; cnt <= cnt-1.
  - cnt = 0: no effect.
- Clear: seg_data <= 0, cnt <= 0, overflow <= 0. entry_value is unchanged.
- Enter or operator:
  - entry_value <= seg_data (pre-clear value).
  - entry_valid and op_valid pulse for exactly 1 cycle; op_code is set as listed under Ports.
  - Buffer cleared: seg_data <= 0, cnt <= 0, overflow <= 0.
  - Enter with cnt=0 still strobes, with entry_value = 0.
- Strobes are low in every cycle without an enter or operator key. Back-to-back pulses on consecutive cycles are each processed.
- seg_data_en: bit i = 1 for i < cnt. Bit 0 is always 1, so an empty buffer displays "0".
- seg_dot_en:
  - cnt < DIGITS: 0; blink counter and phase held at 0.
  - cnt == DIGITS: the blink counter runs. The phase toggles every BLINK_CYCLES cycles, and seg_dot_en[0] = phase; all other bits 0.
  - Leaving the full state (backspace, clear, enter, operator) zeroes the counter and phase on the same edge.
- The counter wraps from BLINK_CYCLES-1 to 0 at each toggle. It is sized $clog2(BLINK_CYCLES).
- Reset asserted mid-operation: immediate return to reset values, including dropping any strobe in flight.

Test Plan:
- Reset, then key bits 0,1,2 (digits 1,2,3) one per 10 cycles -> seg_data[11:0]=12'h123, cnt=3, seg_data_en=8'h07, no strobes.
- Bit 15 (digit 0) from reset -> no change: cnt=0, seg_data=0, seg_data_en=8'h01. Then 1,0 -> seg_data[7:0]=8'h10, cnt=2.
- Enter 1..8 (DIGITS=8), then digit 9 -> seg_data=32'h12345678, overflow=1. With BLINK_CYCLES=4, seg_dot_en[0] toggles every 4 cycles. Then backspace -> seg_data=32'h01234567, cnt=7, seg_dot_en=0.
- Buffer 12'h123, pulse bit 13 -> on the next cycle only: entry_valid=1, op_valid=1, op_code=1, entry_value=32'h00000123; buffer cleared, cnt=0, seg_data_en=8'h01.
- key_pulse=16'h0003 (two bits set), then 16'h0000 -> no state change; clear with empty buffer -> no change; backspace at cnt=0 -> no change.
- Digits 4,5, then rst_n low mid-sequence, asynchronous to clk -> outputs return to reset values before the next edge; a strobe in flight is dropped.
